// File: rtl/uart_pkg.sv
// Shared types and frame constants for the UART transmit and receive paths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Clocks per bit; truncating division.
  function automatic int calc_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter producing a one-cycle tick at the end of each bit
// period. A full load times DIV clocks, a half load DIV/2 clocks; after a
// tick it reloads a full period so it keeps ticking once per bit.
module uart_bit_timer #(
  parameter int DIV = 434
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en,
  input  logic load_full,
  input  logic load_half,
  output logic tick
);

  localparam int CW = (DIV < 2) ? 1 : $clog2(DIV + 1);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'((DIV / 2 > 0) ? (DIV / 2 - 1) : 0);

  logic [CW-1:0] cnt;

  // Loads win over the enable so a timer can be armed from its idle state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)            cnt <= '0;
    else if (load_full)     cnt <= FULL;
    else if (load_half)     cnt <= HALF;
    else if (!en)           cnt <= '0;
    else if (cnt == '0)     cnt <= FULL;
    else                    cnt <= cnt - 1'b1;
  end

  assign tick = en && (cnt == '0);

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: independent TX serializer and RX deserializer
// sharing one clock and reset, each paced by its own bit timer.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tx_enable,
  input  logic       wr,
  input  logic [7:0] wr_data,
  output logic       idle,
  output logic       tx,
  input  logic       rx_enable,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int BCW = $clog2(DATA_BITS);

  // ---------------------------------------------------------------- TX path
  uart_state_e          tx_state, tx_state_n;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
  logic [BCW-1:0]       tx_cnt, tx_cnt_n;
  logic                 tx_q, tx_n;
  logic                 tx_load, tx_tick;

  uart_bit_timer #(.DIV(DIV)) u_tx_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en       (tx_state != IDLE),
    .load_full(tx_load),
    .load_half(1'b0),
    .tick     (tx_tick)
  );

  // TX state, shift register and registered line output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state <= IDLE;
      tx_shift <= '0;
      tx_cnt   <= '0;
      tx_q     <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_shift <= tx_shift_n;
      tx_cnt   <= tx_cnt_n;
      tx_q     <= tx_n;
    end
  end

  // TX next state: the line value for the coming bit is decided here so tx
  // changes on the same edge as the state.
  always_comb begin
    tx_state_n = tx_state;
    tx_shift_n = tx_shift;
    tx_cnt_n   = tx_cnt;
    tx_n       = tx_q;
    tx_load    = 1'b0;
    case (tx_state)
      IDLE: begin
        tx_n = 1'b1;
        if (tx_enable && wr) begin
          tx_state_n = START;
          tx_shift_n = wr_data;
          tx_cnt_n   = '0;
          tx_n       = 1'b0;
          tx_load    = 1'b1;
        end
      end
      START: begin
        if (tx_tick) begin
          tx_state_n = DATA;
          tx_n       = tx_shift[0];
        end
      end
      DATA: begin
        if (tx_tick) begin
          if (tx_cnt == BCW'(DATA_BITS - 1)) begin
            tx_state_n = STOP;
            tx_cnt_n   = '0;
            tx_n       = 1'b1;
          end else begin
            tx_cnt_n   = tx_cnt + 1'b1;
            tx_shift_n = tx_shift >> 1;
            tx_n       = tx_shift[1];
          end
        end
      end
      STOP: begin
        if (tx_tick) begin
          if (tx_cnt == BCW'(STOP_BITS - 1)) tx_state_n = IDLE;
          else                                tx_cnt_n   = tx_cnt + 1'b1;
        end
      end
      default: tx_state_n = IDLE;
    endcase
  end

  assign tx   = tx_q;
  assign idle = (tx_state == IDLE);

  // ---------------------------------------------------------------- RX path
  uart_state_e          rx_state, rx_state_n;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
  logic [BCW-1:0]       rx_cnt, rx_cnt_n;
  logic [7:0]           rx_data_q, rx_data_n;
  logic                 rx_valid_q, rx_valid_n;
  logic                 rx_s1, rx_s2, rx_prev;
  logic                 rx_load, rx_tick;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection;
  // all reset high to match an idle line.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  uart_bit_timer #(.DIV(DIV)) u_rx_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en       (rx_state != IDLE),
    .load_full(1'b0),
    .load_half(rx_load),
    .tick     (rx_tick)
  );

  // RX state, shift register and output byte/pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state   <= IDLE;
      rx_shift   <= '0;
      rx_cnt     <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_state   <= rx_state_n;
      rx_shift   <= rx_shift_n;
      rx_cnt     <= rx_cnt_n;
      rx_data_q  <= rx_data_n;
      rx_valid_q <= rx_valid_n;
    end
  end

  // RX next state: half-bit recheck of the start bit, then mid-bit samples.
  // After a framing error the FSM simply returns to IDLE; a new frame needs
  // a 1->0 edge, so it cannot re-arm until the line has gone high again.
  always_comb begin
    rx_state_n = rx_state;
    rx_shift_n = rx_shift;
    rx_cnt_n   = rx_cnt;
    rx_data_n  = rx_data_q;
    rx_valid_n = 1'b0;
    rx_load    = 1'b0;
    if (!rx_enable) begin
      rx_state_n = IDLE;
    end else begin
      case (rx_state)
        IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state_n = START;
            rx_load    = 1'b1;
          end
        end
        START: begin
          if (rx_tick) begin
            if (rx_s2) begin
              rx_state_n = IDLE;
            end else begin
              rx_state_n = DATA;
              rx_cnt_n   = '0;
            end
          end
        end
        DATA: begin
          if (rx_tick) begin
            rx_shift_n = {rx_s2, rx_shift[DATA_BITS-1:1]};
            if (rx_cnt == BCW'(DATA_BITS - 1)) rx_state_n = STOP;
            else                                rx_cnt_n   = rx_cnt + 1'b1;
          end
        end
        STOP: begin
          if (rx_tick) begin
            rx_state_n = IDLE;
            if (rx_s2) begin
              rx_data_n  = rx_shift;
              rx_valid_n = 1'b1;
            end
          end
        end
        default: rx_state_n = IDLE;
      endcase
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver at default 50 MHz / 115200 baud.
module tb_uart_transceiver;

  localparam int DIV = 434;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       tx_enable = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       idle, tx;
  logic       rx_enable = 1'b0;
  logic       rx_drv = 1'b1;
  logic       loop = 1'b0;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;

  assign rx = loop ? tx : rx_drv;

  uart_transceiver dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .tx_enable(tx_enable),
    .wr       (wr),
    .wr_data  (wr_data),
    .idle     (idle),
    .tx       (tx),
    .rx_enable(rx_enable),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
  );

  always #10 clk_i = ~clk_i;

  int         n_chk = 0;
  int         n_pass = 0;
  int         vcnt = 0;
  int         v0;
  int         lows;
  logic [7:0] got_q[$];

  // Every cycle rx_valid is high counts, so a stretched pulse shows up.
  always @(negedge clk_i) begin
    if (rx_valid) begin
      vcnt++;
      got_q.push_back(rx_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Called #1 after an edge: writes d this cycle, then checks the first and
  // last cycle of every bit plus the exact idle return edge.
  task automatic send_tx(input logic [7:0] d, input bit disturb);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    wr = 1'b1;
    wr_data = d;
    @(posedge clk_i); #1;
    wr = 1'b0;
    wr_data = 8'h3C;
    chk("tx_idle_fall", idle, 0);
    chk("tx_start", tx, 0);
    for (int c = 1; c <= 10 * DIV; c++) begin
      @(posedge clk_i); #1;
      if (disturb) begin
        if (c == 1000) begin wr = 1'b1; wr_data = ~d; end
        if (c == 1001) wr = 1'b0;
        if (c == 2000) tx_enable = 1'b0;
      end
      if (c < 10 * DIV && (c % DIV == 0 || c % DIV == DIV - 1))
        chk($sformatf("tx_bit%0d", c / DIV), tx, fr[c / DIV]);
      if (c == 10 * DIV - 1) chk("tx_idle_low", idle, 0);
      if (c == 10 * DIV) begin
        chk("tx_idle_rise", idle, 1);
        chk("tx_line_idle", tx, 1);
      end
    end
    tx_enable = 1'b1;
  endtask

  // Drives one frame on rx; optionally checks nothing arrived before stop.
  task automatic drive_frame(input logic [7:0] d, input bit stop, input bit mid_chk, input int vb);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rx_drv = fr[b];
      if (b == 9 && mid_chk) chk("rx_early", vcnt, vb);
      wait_cycles(DIV);
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    // reset
    #50;
    chk("rst_tx", tx, 1);
    chk("rst_idle", idle, 1);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 0);
    #5 rst_ni = 1'b1;
    wait_cycles(3);
    tx_enable = 1'b1;
    rx_enable = 1'b1;
    wait_cycles(5);

    // single TX byte
    send_tx(8'hA5, 1'b0);
    chk("tx_no_rx", vcnt, 0);

    // single RX byte
    v0 = vcnt;
    drive_frame(8'h55, 1'b1, 1'b1, v0);
    chk("rx_cnt", vcnt, v0 + 1);
    chk("rx_data55", rx_data, 8'h55);
    chk("rx_valid_low", rx_valid, 0);

    // loopback, then back-to-back frames
    got_q.delete();
    loop = 1'b1;
    wait_cycles(5);
    v0 = vcnt;
    send_tx(8'hA5, 1'b0);
    wait_cycles(10);
    chk("lb_cnt", vcnt, v0 + 1);
    chk("lb_data", rx_data, 8'hA5);
    send_tx(8'h00, 1'b0);
    send_tx(8'hFF, 1'b0);
    wait_cycles(10);
    chk("lb_q_size", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("lb_q0", got_q[0], 8'hA5);
      chk("lb_q1", got_q[1], 8'h00);
      chk("lb_q2", got_q[2], 8'hFF);
    end
    loop = 1'b0;
    wait_cycles(5);

    // 100 ns glitch
    v0 = vcnt;
    rx_drv = 1'b0;
    wait_cycles(5);
    rx_drv = 1'b1;
    wait_cycles(2 * DIV);
    chk("glitch_cnt", vcnt, v0);

    // framing error, then a good frame proves the receiver re-arms
    drive_frame(8'h12, 1'b0, 1'b0, 0);
    wait_cycles(DIV);
    chk("ferr_cnt", vcnt, v0);
    chk("ferr_data", rx_data, 8'hFF);
    drive_frame(8'h3C, 1'b1, 1'b0, 0);
    wait_cycles(20);
    chk("rearm_cnt", vcnt, v0 + 1);
    chk("rearm_data", rx_data, 8'h3C);

    // wr with tx_enable low is ignored
    tx_enable = 1'b0;
    wr = 1'b1;
    wr_data = 8'h81;
    wait_cycles(1);
    wr = 1'b0;
    tx_enable = 1'b1;
    lows = 0;
    for (int i = 0; i < 2 * DIV; i++) begin
      wait_cycles(1);
      if (!tx || !idle) lows++;
    end
    chk("txen0_quiet", lows, 0);

    // mid-frame wr and tx_enable drop leave the frame intact, no extra frame
    send_tx(8'h96, 1'b1);
    lows = 0;
    for (int i = 0; i < 2 * DIV; i++) begin
      wait_cycles(1);
      if (!tx || !idle) lows++;
    end
    chk("busy_wr_quiet", lows, 0);

    // receiver disabled
    rx_enable = 1'b0;
    v0 = vcnt;
    drive_frame(8'h77, 1'b1, 1'b0, 0);
    wait_cycles(20);
    chk("rxen0_cnt", vcnt, v0);
    chk("rxen0_data", rx_data, 8'h3C);

    // rx_enable dropped mid-frame aborts it
    rx_enable = 1'b1;
    wait_cycles(5);
    rx_drv = 1'b0;
    wait_cycles(2 * DIV);
    rx_enable = 1'b0;
    wait_cycles(DIV);
    rx_enable = 1'b1;
    rx_drv = 1'b1;
    wait_cycles(10 * DIV);
    chk("rx_abort_cnt", vcnt, v0);

    // reset in the middle of a TX frame
    wr = 1'b1;
    wr_data = 8'h00;
    wait_cycles(1);
    wr = 1'b0;
    wait_cycles(1000);
    chk("midrst_pre_tx", tx, 0);
    rst_ni = 1'b0;
    #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_idle", idle, 1);
    chk("midrst_rx_data", rx_data, 8'h00);
    chk("midrst_rx_valid", rx_valid, 0);
    #3 rst_ni = 1'b1;
    wait_cycles(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
